hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage RISC-V core: drives enables/clears of PC, IF_ID, ID_EX, EX_MEM.
//  Handles load-use stalls, taken-branch/jump flushes (resolved in MEM), and data-memory wait freezes.
//  Keeps wrapping stall/flush event counters plus a sticky memory-timeout flag.
// PARAMETERS
//  CNT_WIDTH  16  width of stall_count / flush_count
//  MAX_WAIT   15  consecutive dmem wait cycles tolerated before mem_timeout sets (>=1)
// PORTS
//  clk            in   1          rising-edge clock
//  clear          in   1          async active-high reset
//  mem_read_ex    in   1          load in EX
//  rd_ex          in   5          destination register of EX instruction
//  rs1_id         in   5          source 1 of ID instruction
//  rs2_id         in   5          source 2 of ID instruction
//  rs1_used_id    in   1          ID instruction reads rs1
//  rs2_used_id    in   1          ID instruction reads rs2
//  branch_taken_mem in 1          branch/jump in MEM redirects PC this cycle
//  mem_access_mem in   1          load or store in MEM
//  dmem_ready     in   1          data memory completes access this cycle
//  pc_en          out  1          PC load enable
//  if_id_en       out  1          IF_ID load enable
//  id_ex_en       out  1          ID_EX load enable
//  ex_mem_en      out  1          EX_MEM load enable
//  id_ex_bubble   out  1          sync clear of ID_EX at next edge (insert NOP)
//  flush_front    out  1          sync clear of IF_ID, ID_EX, EX_MEM at next edge
//  mem_kill       out  1          suppress mem_write / reg_write of instruction now in MEM
//  stall_count    out  CNT_WIDTH  cycles with pc_en==0
//  flush_count    out  CNT_WIDTH  flush events entered
//  mem_timeout    out  1          sticky: dmem wait exceeded MAX_WAIT
// BEHAVIOUR
//  Reset (clear=1, async): state=RUN, counters=0, wait_cnt=0, mem_timeout=0; outputs settle to
//   pc_en=if_id_en=id_ex_en=ex_mem_en=1, bubble/flush/kill=0.
//  States: RUN, FLUSH, WAIT (one-hot flops). flush_front and mem_kill decode from state only.
//  load_use = mem_read_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
//  mem_wait = mem_access_mem & ~dmem_ready.
//  Priority each cycle: mem_wait > FLUSH/branch_taken_mem > load_use.
//  RUN:
//   - mem_wait: all four enables 0 (combinational, same cycle), bubble=0; -> WAIT.
//   - else branch_taken_mem: enables 1 (PC takes target); -> FLUSH. load_use ignored.
//   - else load_use: pc_en=if_id_en=0, id_ex_en=1, id_ex_bubble=1 for exactly that cycle; stay RUN.
//     Next cycle rd match clears naturally (load advanced), so one stall cycle per load-use.
//   - else all enables 1.
//  FLUSH (exactly one cycle): flush_front=1, mem_kill=1, enables 1, load_use ignored.
//   - mem_wait ignored (wrong-path access killed); -> RUN unless branch_taken_mem=0 is false
//     (branch_taken_mem in FLUSH comes from a killed instr and is ignored); always -> RUN.
//  WAIT: all enables 0 while mem_wait; wait_cnt increments (saturating at MAX_WAIT).
//   - wait_cnt reaching MAX_WAIT while still waiting sets mem_timeout (sticky until clear); keep freezing.
//   - dmem_ready=1: enables evaluated as in RUN for this cycle (branch/load_use rules apply), wait_cnt=0,
//     next state per RUN rules (FLUSH if branch_taken_mem, else RUN).
//  stall_count += 1 every cycle pc_en==0; flush_count += 1 on each RUN/WAIT->FLUSH transition;
//   both wrap modulo 2^CNT_WIDTH.
//  Reset mid-WAIT or mid-FLUSH: immediate return to RUN values; mem_timeout cleared.
//  Latency: stall/freeze enables are same-cycle; flush is one cycle after branch_taken_mem.
// TESTING
//  1 Reset: clear pulse mid-clock -> enables 1, flush/kill 0, counters 0 before next edge.
//  2 lw x5 in EX, add rs1=x5 in ID -> one cycle pc_en=0,if_id_en=0,id_ex_bubble=1; stall_count=1.
//  3 Load to x0 with rs1=x0 user -> no stall; rd_ex=5, rs2=5 but rs2_used_id=0 -> no stall.
//  4 branch_taken_mem=1 at cycle N -> cycle N+1 flush_front=1,mem_kill=1; N+2 RUN; flush_count=1.
//  5 mem_access with dmem_ready low 3 cycles (MAX_WAIT=15) -> enables 0 for 3 cycles, stall_count=3,
//    no timeout; hold low 16 cycles -> mem_timeout=1 and stays after ready.
//  6 Simultaneous mem_wait+branch_taken_mem+load_use -> freeze first; on ready -> FLUSH next cycle;
//    counter wrap with CNT_WIDTH=4: 16 stalls -> stall_count=0.

Source files
------------

// File: rtl/hazard_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_flush_ctrl_if
// Description : Hazard inputs and pipeline-control outputs between the
//               datapath (master) and the hazard/flush sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_flush_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 mem_read_ex;
    logic [4:0]           rd_ex;
    logic [4:0]           rs1_id;
    logic [4:0]           rs2_id;
    logic                 rs1_used_id;
    logic                 rs2_used_id;
    logic                 branch_taken_mem;
    logic                 mem_access_mem;
    logic                 dmem_ready;
    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_mem_en;
    logic                 id_ex_bubble;
    logic                 flush_front;
    logic                 mem_kill;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;
    logic                 mem_timeout;

    modport master (
        output mem_read_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
               branch_taken_mem, mem_access_mem, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, flush_front,
               mem_kill, stall_count, flush_count, mem_timeout
    );

    modport slave (
        input  mem_read_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
               branch_taken_mem, mem_access_mem, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, flush_front,
               mem_kill, stall_count, flush_count, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_flush_ctrl
// Description : 5-stage pipeline sequencer: load-use stalls, MEM-resolved
//               branch flushes, dmem wait freezes, event counters, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_flush_ctrl #(
    parameter int CNT_WIDTH = 16,
    parameter int MAX_WAIT  = 15
) (
    input  wire logic          clk,
    input  wire logic          clear,
    hazard_flush_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'b001,
        ST_FLUSH = 3'b010,
        ST_WAIT  = 3'b100
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
    logic                 mem_timeout_q, mem_timeout_d;

    logic w_load_use;
    logic w_mem_wait;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_bubble;
    logic w_flush_front;
    logic w_mem_kill;

    assign w_load_use = bus.mem_read_ex && (bus.rd_ex != 5'd0) &&
                        ((bus.rs1_used_id && (bus.rs1_id == bus.rd_ex)) ||
                         (bus.rs2_used_id && (bus.rs2_id == bus.rd_ex)));
    assign w_mem_wait = bus.mem_access_mem && !bus.dmem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_bubble      = 1'b0;
        w_flush_front = 1'b0;
        w_mem_kill    = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                // Anything presented in MEM now belongs to the wrong path.
                w_flush_front = 1'b1;
                w_mem_kill    = 1'b1;
                wait_cnt_d    = '0;
                state_d       = ST_RUN;
            end
            default: begin
                if (w_mem_wait) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    state_d     = ST_WAIT;
                    // wait_cnt holds wait cycles already completed.
                    if (state_q != ST_WAIT) begin
                        wait_cnt_d = WAIT_W'(1);
                    end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                    if (bus.branch_taken_mem) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                        if (w_load_use) begin
                            w_pc_en    = 1'b0;
                            w_if_id_en = 1'b0;
                            w_bubble   = 1'b1;
                        end
                    end
                end
            end
        endcase

        stall_count_d = w_pc_en ? stall_count_q : stall_count_q + CNT_WIDTH'(1);
        flush_count_d = ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)) ?
                        flush_count_q + CNT_WIDTH'(1) : flush_count_q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.id_ex_bubble = w_bubble;
    assign bus.flush_front  = w_flush_front;
    assign bus.mem_kill     = w_mem_kill;
    assign bus.stall_count  = stall_count_q;
    assign bus.flush_count  = flush_count_q;
    assign bus.mem_timeout  = mem_timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_flush_ctrl
// Description : Directed scoreboard bench for hazard_flush_ctrl (4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_flush_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    hazard_flush_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    hazard_flush_ctrl #(
        .CNT_WIDTH(CW),
        .MAX_WAIT (15)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0]    en;
        logic          bub;
        logic          fl;
        logic          kl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic          tmo;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic ma, input logic rdy);
        bus.mem_read_ex      = mr;
        bus.rd_ex            = rd;
        bus.rs1_id           = rs1;
        bus.rs2_id           = rs2;
        bus.rs1_used_id      = u1;
        bus.rs2_used_id      = u2;
        bus.branch_taken_mem = br;
        bus.mem_access_mem   = ma;
        bus.dmem_ready       = rdy;
    endtask

    // Expected counters are those visible during the cycle; a flush cycle
    // already reflects its own entry, a stall cycle shows up one cycle later.
    task automatic push(input logic [3:0] en, input logic bub, input logic fl, input logic tmo);
        exp_t e;
        if (fl) m_flush = m_flush + 1'b1;
        e.en  = en;
        e.bub = bub;
        e.fl  = fl;
        e.kl  = fl;
        e.sc  = m_stall;
        e.fc  = m_flush;
        e.tmo = tmo;
        sb.push_back(e);
        if (!en[3]) m_stall = m_stall + 1'b1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp("enables", 32'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en}), 32'(e.en));
        cmp("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e.bub));
        cmp("flush_front", 32'(bus.flush_front), 32'(e.fl));
        cmp("mem_kill", 32'(bus.mem_kill), 32'(e.kl));
        cmp("stall_count", 32'(bus.stall_count), 32'(e.sc));
        cmp("flush_count", 32'(bus.flush_count), 32'(e.fc));
        cmp("mem_timeout", 32'(bus.mem_timeout), 32'(e.tmo));
    endtask

    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic br, input logic ma, input logic rdy,
                        input logic [3:0] en, input logic bub, input logic fl, input logic tmo);
        @(negedge clk);
        drive(mr, rd, rs1, rs2, u1, u2, br, ma, rdy);
        push(en, bub, fl, tmo);
        #2;
        check();
    endtask

    task automatic idle(input logic tmo);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 0, 0, tmo);
    endtask

    task automatic wait_cyc(input logic tmo);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, tmo);
    endtask

    // Asynchronous clear asserted between edges; results must settle before the next edge.
    task automatic mid_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        clear = 1'b1;
        m_stall = '0;
        m_flush = '0;
        push(4'hF, 0, 0, 0);
        #1;
        check();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        mid_reset();
        idle(0);

        // load-use on rs1 and on rs2: single stall cycle with bubble
        step(1, 5, 5, 0, 1, 0, 0, 0, 1, 4'b0011, 1, 0, 0);
        idle(0);
        step(1, 7, 0, 7, 0, 1, 0, 0, 1, 4'b0011, 1, 0, 0);
        // x0 destination and unused rs2 never stall
        step(1, 0, 0, 0, 1, 1, 0, 0, 1, 4'hF, 0, 0, 0);
        step(1, 5, 0, 5, 1, 0, 0, 0, 1, 4'hF, 0, 0, 0);

        // taken branch -> flush next cycle, which ignores load-use/mem_wait/branch
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 4'hF, 0, 0, 0);
        step(1, 5, 5, 0, 1, 0, 1, 1, 0, 4'hF, 0, 1, 0);
        idle(0);

        // short dmem wait, then exactly MAX_WAIT cycles (no timeout)
        repeat (3) wait_cyc(0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        repeat (15) wait_cyc(0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        // one cycle beyond MAX_WAIT sets the sticky timeout; also wraps stall_count
        repeat (16) wait_cyc(0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 0, 0, 1);
        idle(1);

        // release from WAIT straight into a load-use stall
        wait_cyc(1);
        step(1, 5, 5, 0, 1, 0, 0, 1, 1, 4'b0011, 1, 0, 1);
        idle(1);

        // mem_wait + branch + load-use together: freeze, then flush after ready
        step(1, 5, 5, 0, 1, 0, 1, 1, 0, 4'h0, 0, 0, 1);
        step(1, 5, 5, 0, 1, 0, 1, 1, 0, 4'h0, 0, 0, 1);
        step(1, 5, 5, 0, 1, 0, 1, 1, 1, 4'hF, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 1, 1);
        idle(1);

        // clear mid-WAIT clears the timeout and counters
        wait_cyc(1);
        mid_reset();
        idle(0);

        // clear mid-FLUSH
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 4'hF, 0, 0, 0);
        mid_reset();
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
